// File: rtl/sub_pkg.sv
// Shared types and default sizing for the serial subtractor.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_STEP  = 1;

endpackage

// File: rtl/serial_sub_if.sv
// Request/result bundle for serial_sub. Defining SERIAL_SUB_OVF_EN adds the ovf result bit.
interface serial_sub_if
  import sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (output start, a, b, bin, input busy, done, diff, bout, ovf);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout, ovf);
`else
  modport master (output start, a, b, bin, input busy, done, diff, bout);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout);
`endif

endinterface

// File: rtl/serial_sub_full_sub.sv
// One-bit full subtractor cell; STEP copies form the per-cycle borrow chain.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// Multi-cycle subtractor: diff = a - b - bin over WIDTH/STEP cycles, STEP bits per cycle.
// Defining SERIAL_SUB_OVF_EN adds a registered signed-overflow flag (ovf).
module serial_sub
  import sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEP  = DEF_STEP
) (
  input  logic         clk,
  input  logic         rst,
  serial_sub_if.slave  bus
);

  localparam int N     = WIDTH / STEP;
  localparam int CNT_W = $clog2(N + 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, diff_q;
  logic [WIDTH-1:0] a_d, b_d, diff_d;
  logic             borrow_q;
  logic             bout_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] cnt_q;
  logic [STEP:0]    br;
  logic [STEP-1:0]  d_step;
  logic             last_step;

  assign br[0] = borrow_q;

  for (genvar i = 0; i < STEP; i++) begin : g_chain
    full_sub u_full_sub (
      .a    (a_q[i]),
      .b    (b_q[i]),
      .bin  (br[i]),
      .d    (d_step[i]),
      .bout (br[i+1])
    );
  end

  // NOTE: every output of this block is assigned unconditionally, so no latch can be inferred.
  always_comb begin
    a_d    = a_q >> STEP;
    b_d    = b_q >> STEP;
    // New result bits enter at the top; after N shifts the LSB chunk sits at bit 0.
    diff_d = (diff_q >> STEP) | (WIDTH'(d_step) << (WIDTH - STEP));
  end

  assign last_step = (cnt_q == CNT_W'(N - 1));

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q;
  assign bus.ovf = ovf_q;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: operand registers are reset too; they are few flops and keep simulation X-free.
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        RUN: begin
          a_q      <= a_d;
          b_q      <= b_d;
          borrow_q <= br[STEP];
          diff_q   <= diff_d;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (last_step) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            bout_q  <= br[STEP];
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= br[STEP-1] ^ br[STEP];
`endif
          end
        end
        default: begin
          // IDLE and DONE both accept a new request, giving back-to-back operation.
          done_q <= 1'b0;
          if (bus.start) begin
            a_q      <= bus.a;
            b_q      <= bus.b;
            borrow_q <= bus.bin;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end else begin
            state_q  <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub: STEP=1 and STEP=4 instances, directed vectors.
module tb_serial_sub;

  typedef struct {
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_sub_if #(.WIDTH(8)) bus1 ();
  serial_sub_if #(.WIDTH(8)) bus2 ();

  serial_sub #(.WIDTH(8), .STEP(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  serial_sub #(.WIDTH(8), .STEP(4)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : mon1
    exp_t e;
    if (bus1.done) begin
      check("d1_done_expected", 32'(q1.size() != 0), 1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        check("d1_diff", bus1.diff, e.diff);
        check("d1_bout", bus1.bout, e.bout);
        check("d1_latency", cyc, e.cyc);
`ifdef SERIAL_SUB_OVF_EN
        check("d1_ovf", bus1.ovf, e.ovf);
`endif
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (bus2.done) begin
      check("d2_done_expected", 32'(q2.size() != 0), 1);
      if (q2.size() != 0) begin
        e = q2.pop_front();
        check("d2_diff", bus2.diff, e.diff);
        check("d2_bout", bus2.bout, e.bout);
        check("d2_latency", cyc, e.cyc);
`ifdef SERIAL_SUB_OVF_EN
        check("d2_ovf", bus2.ovf, e.ovf);
`endif
      end
    end
  end

  task automatic op1(input logic [7:0] a, input logic [7:0] b, input logic bin,
                     input logic [7:0] ed, input logic eb, input logic eo);
    @(negedge clk);
    bus1.start = 1'b1; bus1.a = a; bus1.b = b; bus1.bin = bin;
    @(posedge clk); #1;
    q1.push_back('{ed, eb, eo, cyc + 8});
    @(negedge clk);
    bus1.start = 1'b0;
    check("d1_busy_after_start", bus1.busy, 1);
  endtask

  task automatic op2(input logic [7:0] a, input logic [7:0] b, input logic bin,
                     input logic [7:0] ed, input logic eb, input logic eo);
    @(negedge clk);
    bus2.start = 1'b1; bus2.a = a; bus2.b = b; bus2.bin = bin;
    @(posedge clk); #1;
    q2.push_back('{ed, eb, eo, cyc + 2});
    @(negedge clk);
    bus2.start = 1'b0;
  endtask

  task automatic drain1();
    int k = 0;
    while ((q1.size() != 0 || bus1.busy) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("d1_drain_timeout", 32'(k < 100), 1);
  endtask

  task automatic drain2();
    int k = 0;
    while ((q2.size() != 0 || bus2.busy) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("d2_drain_timeout", 32'(k < 100), 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int pulses;
    rst = 1'b1;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.bin = 1'b0;
    bus2.start = 1'b0; bus2.a = '0; bus2.b = '0; bus2.bin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("d1_rst_busy", bus1.busy, 0);
    check("d1_rst_done", bus1.done, 0);
    check("d1_rst_diff", bus1.diff, 0);
    check("d1_rst_bout", bus1.bout, 0);
    check("d2_rst_busy", bus2.busy, 0);
    check("d2_rst_diff", bus2.diff, 0);
    rst = 1'b0;

    // Basic subtractions, STEP=1.
    op1(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0); drain1();
    op1(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0); drain1();
    op1(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0); drain1();
    op1(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1); drain1();

    // Result holds after DONE.
    repeat (3) @(negedge clk);
    check("d1_hold_diff", bus1.diff, 8'h7F);
    check("d1_hold_bout", bus1.bout, 0);
    check("d1_idle_done", bus1.done, 0);

    // Start pulse mid-RUN is ignored.
    op1(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    bus1.start = 1'b1; bus1.a = 8'hFF; bus1.b = 8'h00; bus1.bin = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    check("d1_busy_ignore", bus1.busy, 1);
    drain1();
    repeat (12) @(negedge clk);
    check("d1_idle_after_ignore", bus1.busy, 0);

    // STEP=4: back-to-back with start held through DONE.
    @(negedge clk);
    bus2.start = 1'b1; bus2.a = 8'hA5; bus2.b = 8'h5A; bus2.bin = 1'b0;
    @(posedge clk); #1;
    q2.push_back('{8'h4B, 1'b0, 1'b1, cyc + 2});
    @(negedge clk);
    bus2.a = 8'h12; bus2.b = 8'h34; bus2.bin = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    q2.push_back('{8'hDD, 1'b1, 1'b0, cyc + 2});
    @(negedge clk);
    bus2.start = 1'b0;
    check("d2_busy_b2b", bus2.busy, 1);
    drain2();
    op2(8'hF0, 8'h0F, 1'b1, 8'hE0, 1'b0, 1'b0); drain2();

    // Reset on the third RUN edge discards the operation.
    @(negedge clk);
    bus1.start = 1'b1; bus1.a = 8'h22; bus1.b = 8'h11; bus1.bin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus1.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("d1_midrst_busy", bus1.busy, 0);
    check("d1_midrst_diff", bus1.diff, 0);
    check("d1_midrst_bout", bus1.bout, 0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus1.done) pulses++;
    end
    check("d1_no_done_after_rst", pulses, 0);

    // Recovery after reset.
    op1(8'h22, 8'h11, 1'b0, 8'h11, 1'b0, 1'b0); drain1();

    check("q1_empty", q1.size(), 0);
    check("q2_empty", q2.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
